// File: rtl/ex_ctrl_pkg.sv
// Shared encodings for the execute-stage pipeline sequencer: control bundle
// field positions, forwarding selects and ALUOp values.
package ex_ctrl_pkg;

  localparam int CTRL_W   = 8;
  localparam int REGWRITE = 7;
  localparam int MEMTOREG = 6;
  localparam int MEMREAD  = 5;
  localparam int MEMWRITE = 4;
  localparam int BRANCH   = 3;
  localparam int ALUSRC   = 2;
  localparam int ALUOP_HI = 1;
  localparam int ALUOP_LO = 0;

  // EX/MEM keeps only the upper nibble {regwrite, memtoreg, memread, memwrite}
  localparam int MEM_CTRL_W   = 4;
  localparam int MEM_REGWRITE = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10
  } aluop_e;

endpackage

// File: rtl/ex_hazard_detect.sv
// Combinational load-use and taken-branch detection with branch-over-stall
// priority; also tells the top when ID/EX must take a bubble.
module ex_hazard_detect
  import ex_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_branch,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_zero,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              pc_sel,
  output logic              bubble
);

  logic load_use;
  logic branch_taken;

  always_comb begin
    load_use     = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    branch_taken = ex_valid & ex_branch & ex_zero;

    // a taken branch discards the stalled instruction, so no stall is reported
    stall_if_id  = load_use & ~branch_taken;
    flush_if_id  = branch_taken;
    pc_sel       = branch_taken;
    bubble       = ~id_valid | load_use | branch_taken;
  end

endmodule

// File: rtl/ex_pipeline_ctrl.sv
// Control half of the ID/EX, EX/MEM and MEM/WB registers, operand forwarding
// selects and saturating stall/flush counters for the RV64 execute datapath.
module ex_pipeline_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [7:0]        id_ctrl,
  input  logic              ex_zero,
  output logic              ex_valid,
  output logic [7:0]        ex_ctrl,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic [3:0]        mem_ctrl,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              pc_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic bubble;

  ex_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl[MEMREAD]),
    .ex_branch   (ex_ctrl[BRANCH]),
    .ex_rd       (ex_rd),
    .ex_zero     (ex_zero),
    .stall_if_id (stall_if_id),
    .flush_if_id (flush_if_id),
    .pc_sel      (pc_sel),
    .bubble      (bubble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_ctrl  <= id_ctrl;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_ctrl    <= '0;
      mem_rd      <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
    end else begin
      mem_valid   <= ex_valid;
      mem_ctrl    <= ex_ctrl[7:4];
      mem_rd      <= ex_rd;
      wb_valid    <= mem_valid;
      wb_regwrite <= mem_ctrl[MEM_REGWRITE];
      wb_rd       <= mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_if_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // EX/MEM is the younger producer, so it is checked first
  function automatic logic [1:0] fwd_for(
    input logic [REG_AW-1:0] rs,
    input logic              m_valid,
    input logic              m_regwrite,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_valid,
    input logic              w_regwrite,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (m_valid && m_regwrite && (m_rd != '0) && (m_rd == rs))
      sel = FWD_MEM;
    else if (w_valid && w_regwrite && (w_rd != '0) && (w_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_for(ex_rs1, mem_valid, mem_ctrl[MEM_REGWRITE], mem_rd,
                    wb_valid, wb_regwrite, wb_rd);
    fwd_b = fwd_for(ex_rs2, mem_valid, mem_ctrl[MEM_REGWRITE], mem_rd,
                    wb_valid, wb_regwrite, wb_rd);
  end

endmodule

// File: tb/tb_ex_pipeline_ctrl.sv
// Directed bench for ex_pipeline_ctrl; a second instance with 4-bit counters
// shares the stimulus so counter saturation can be reached quickly.
module tb_ex_pipeline_ctrl;
  import ex_ctrl_pkg::*;

  localparam int AW = 5;
  localparam logic [7:0] C_ALU  = 8'h82;  // regwrite, aluop=10
  localparam logic [7:0] C_LW   = 8'hE4;  // regwrite, memtoreg, memread, alusrc
  localparam logic [7:0] C_BEQ  = 8'h09;  // branch, aluop=01
  localparam logic [7:0] C_LDBR = 8'h29;  // memread + branch

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [7:0]    id_ctrl = '0;
  logic          ex_zero = 1'b0;

  logic          ex_valid, mem_valid, wb_valid, wb_regwrite;
  logic [7:0]    ex_ctrl;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [3:0]    mem_ctrl;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_if_id, flush_if_id, pc_sel;
  logic [31:0]   stall_cnt, flush_cnt;

  logic          s_ex_valid, s_mem_valid, s_wb_valid, s_wb_regwrite;
  logic [7:0]    s_ex_ctrl;
  logic [AW-1:0] s_ex_rs1, s_ex_rs2, s_ex_rd, s_mem_rd, s_wb_rd;
  logic [3:0]    s_mem_ctrl;
  logic [1:0]    s_fwd_a, s_fwd_b;
  logic          s_stall_if_id, s_flush_if_id, s_pc_sel;
  logic [3:0]    s_stall_cnt, s_flush_cnt;

  ex_pipeline_ctrl #(.REG_AW(AW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .ex_zero(ex_zero), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .pc_sel(pc_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ex_pipeline_ctrl #(.REG_AW(AW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .ex_zero(ex_zero), .ex_valid(s_ex_valid),
    .ex_ctrl(s_ex_ctrl), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .mem_valid(s_mem_valid), .mem_ctrl(s_mem_ctrl), .mem_rd(s_mem_rd), .wb_valid(s_wb_valid),
    .wb_regwrite(s_wb_regwrite), .wb_rd(s_wb_rd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_if_id(s_stall_if_id), .flush_if_id(s_flush_if_id), .pc_sel(s_pc_sel),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic [7:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 5'd6, C_LW);
    #2;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
      n_fail++; $display("FAIL reset_ex: valid=%0b ctrl=%0h required 0/0", ex_valid, ex_ctrl);
    end
    n_checks++;
    if (mem_valid !== 1'b0 || wb_valid !== 1'b0 || wb_regwrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_wb: mem_valid=%0b wb_valid=%0b wb_regwrite=%0b required 0", mem_valid, wb_valid, wb_regwrite);
    end
    n_checks++;
    if ({fwd_a, fwd_b, stall_if_id, flush_if_id, pc_sel} !== 7'b0) begin
      n_fail++; $display("FAIL reset_comb: fwd_a=%0b fwd_b=%0b stall=%0b flush=%0b pc_sel=%0b required 0", fwd_a, fwd_b, stall_if_id, flush_if_id, pc_sel);
    end
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || s_stall_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt: stall_cnt=%0d flush_cnt=%0d sat=%0d required 0", stall_cnt, flush_cnt, s_stall_cnt);
    end
    set_id(1'b0, '0, '0, '0, '0);
    #6;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_mem_priority();
    idle(3);
    set_id(1'b1, 5'd1, 5'd2, 5'd5, C_ALU);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 5'd5, C_ALU);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, C_ALU);
    n_checks++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL fwd_no_stall: stall_if_id=%0b required 0", stall_if_id);
    end
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      n_fail++; $display("FAIL fwd_ex_load: ex_valid=%0b ex_rd=%0d required 1/6", ex_valid, ex_rd);
    end
    n_checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem_prio: fwd_a=%0b fwd_b=%0b required 10/10", fwd_a, fwd_b);
    end
  endtask

  task automatic test_load_use();
    idle(3);
    set_id(1'b1, 5'd1, 5'd0, 5'd7, C_LW);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 5'd8, C_ALU);
    n_checks++;
    if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
      n_fail++; $display("FAIL lu_stall: stall=%0b flush=%0b required 1/0", stall_if_id, flush_if_id);
    end
    tick();
    exp_stall++;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
      n_fail++; $display("FAIL lu_bubble: ex_valid=%0b ex_ctrl=%0h required 0/0", ex_valid, ex_ctrl);
    end
    n_checks++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL lu_one_cycle: stall=%0b required 0", stall_if_id);
    end
    n_checks++;
    if (stall_cnt !== 32'(exp_stall) || s_stall_cnt !== 4'(exp_stall)) begin
      n_fail++; $display("FAIL lu_cnt: stall_cnt=%0d sat=%0d required %0d", stall_cnt, s_stall_cnt, exp_stall);
    end
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (ex_valid !== 1'b1 || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL lu_fwd_wb: ex_valid=%0b fwd_a=%0b fwd_b=%0b required 1/01/00", ex_valid, fwd_a, fwd_b);
    end
  endtask

  task automatic test_x0();
    idle(3);
    set_id(1'b1, 5'd1, 5'd0, 5'd0, C_LW);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, C_ALU);
    n_checks++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_stall: stall=%0b required 0", stall_if_id);
    end
    tick();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL x0_fwd_mem: fwd_a=%0b fwd_b=%0b ex_valid=%0b required 00/00/1", fwd_a, fwd_b, ex_valid);
    end
    tick();
    n_checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL x0_fwd_wb: fwd_a=%0b fwd_b=%0b stall_cnt=%0d required 00/00/%0d", fwd_a, fwd_b, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch();
    idle(3);
    set_id(1'b1, 5'd1, 5'd2, 5'd0, C_BEQ);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 5'd10, C_ALU);
    ex_zero = 1'b1;
    #1;
    n_checks++;
    if (pc_sel !== 1'b1 || flush_if_id !== 1'b1 || stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL br_taken: pc_sel=%0b flush=%0b stall=%0b required 1/1/0", pc_sel, flush_if_id, stall_if_id);
    end
    tick();
    exp_flush++;
    ex_zero = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b0 || flush_cnt !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL br_squash: ex_valid=%0b flush_cnt=%0d required 0/%0d", ex_valid, flush_cnt, exp_flush);
    end
    set_id(1'b1, 5'd1, 5'd2, 5'd0, C_BEQ);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 5'd10, C_ALU);
    n_checks++;
    if (pc_sel !== 1'b0 || flush_if_id !== 1'b0) begin
      n_fail++; $display("FAIL br_not_taken: pc_sel=%0b flush=%0b required 0/0", pc_sel, flush_if_id);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || flush_cnt !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL br_nt_advance: ex_valid=%0b ex_rd=%0d flush_cnt=%0d required 1/10/%0d", ex_valid, ex_rd, flush_cnt, exp_flush);
    end
  endtask

  task automatic test_branch_over_load_use();
    idle(3);
    set_id(1'b1, 5'd1, 5'd2, 5'd11, C_LDBR);
    tick();
    set_id(1'b1, 5'd11, 5'd3, 5'd12, C_ALU);
    ex_zero = 1'b1;
    #1;
    n_checks++;
    if (flush_if_id !== 1'b1 || stall_if_id !== 1'b0 || pc_sel !== 1'b1) begin
      n_fail++; $display("FAIL brlu_prio: flush=%0b stall=%0b pc_sel=%0b required 1/0/1", flush_if_id, stall_if_id, pc_sel);
    end
    tick();
    exp_flush++;
    ex_zero = 1'b0;
    set_id(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush) || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL brlu_cnt: stall_cnt=%0d flush_cnt=%0d ex_valid=%0b required %0d/%0d/0", stall_cnt, flush_cnt, ex_valid, exp_stall, exp_flush);
    end
  endtask

  task automatic test_back_to_back_loads();
    idle(3);
    set_id(1'b1, 5'd1, 5'd0, 5'd12, C_LW);
    tick();
    set_id(1'b1, 5'd12, 5'd0, 5'd13, C_LW);
    n_checks++;
    if (stall_if_id !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall1: stall=%0b required 1", stall_if_id);
    end
    tick();
    tick();
    exp_stall++;
    set_id(1'b1, 5'd13, 5'd2, 5'd14, C_ALU);
    n_checks++;
    if (ex_rd !== 5'd13 || stall_if_id !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall2: ex_rd=%0d stall=%0b required 13/1", ex_rd, stall_if_id);
    end
    tick();
    tick();
    exp_stall++;
    set_id(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (ex_rd !== 5'd14 || fwd_a !== 2'b01 || stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL b2b_done: ex_rd=%0d fwd_a=%0b stall_cnt=%0d required 14/01/%0d", ex_rd, fwd_a, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset_mid();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd5, 5'd5, 5'd5, C_ALU);
      tick();
    end
    n_checks++;
    if (ex_valid !== 1'b1 || mem_valid !== 1'b1 || wb_valid !== 1'b1 || fwd_a !== 2'b10) begin
      n_fail++; $display("FAIL rm_full: ex=%0b mem=%0b wb=%0b fwd_a=%0b required 1/1/1/10", ex_valid, mem_valid, wb_valid, fwd_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ex_valid, mem_valid, wb_valid, wb_regwrite, ex_ctrl, mem_ctrl} !== 16'b0 ||
        {ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} !== 25'b0) begin
      n_fail++; $display("FAIL rm_regs: ex=%0b mem=%0b wb=%0b ex_ctrl=%0h ex_rd=%0d mem_rd=%0d wb_rd=%0d required 0", ex_valid, mem_valid, wb_valid, ex_ctrl, ex_rd, mem_rd, wb_rd);
    end
    n_checks++;
    if ({fwd_a, fwd_b, stall_if_id, flush_if_id, pc_sel} !== 7'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rm_comb_cnt: fwd_a=%0b fwd_b=%0b stall=%0b stall_cnt=%0d flush_cnt=%0d required 0", fwd_a, fwd_b, stall_if_id, stall_cnt, flush_cnt);
    end
    exp_stall = 0;
    exp_flush = 0;
    set_id(1'b0, '0, '0, '0, '0);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    idle(3);
    for (int i = 0; i < 16; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 5'd7, C_LW);
      tick();
      set_id(1'b1, 5'd7, 5'd1, 5'd8, C_ALU);
      tick();
      tick();
      exp_stall++;
      set_id(1'b0, '0, '0, '0, '0);
      if (i == 13) begin
        n_checks++;
        if (s_stall_cnt !== 4'd14) begin
          n_fail++; $display("FAIL sat_count14: sat stall_cnt=%0d required 14", s_stall_cnt);
        end
      end
    end
    n_checks++;
    if (s_stall_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_hold: sat stall_cnt=%0d required 15", s_stall_cnt);
    end
    n_checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL sat_wide: stall_cnt=%0d required %0d", stall_cnt, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_mem_priority();
    test_load_use();
    test_x0();
    test_branch();
    test_branch_over_load_use();
    test_back_to_back_loads();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
